// File: rtl/alu_issue_pkg.sv
// Shared constants for the ALU issue slice. These are the operation codes, RV opcodes and funct7 values.
// The issue-entry record is also defined here.
package alu_issue_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 5;

  typedef enum logic [OPW-1:0] {
    OP_ADD  = 5'd0,
    OP_SUB  = 5'd1,
    OP_SLL  = 5'd2,
    OP_SLTU = 5'd3,
    OP_XOR  = 5'd4,
    OP_SRL  = 5'd5,
    OP_SRA  = 5'd6,
    OP_OR   = 5'd7,
    OP_AND  = 5'd8,
    OP_LUI  = 5'd9,
    OP_MUL  = 5'd10,
    OP_DIV  = 5'd11,
    OP_DIVU = 5'd12,
    OP_REM  = 5'd13,
    OP_REMU = 5'd14,
    OP_NONE = 5'd31
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef struct packed {
    logic [XLEN-1:0] ip1;
    logic [XLEN-1:0] ip2;
    alu_op_t         operation;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } issue_entry_t;

  localparam issue_entry_t ENTRY_RESET = '{
    ip1: '0, ip2: '0, operation: OP_NONE, rd: 5'd0, rd_we: 1'b0, illegal: 1'b0
  };

  function automatic logic is_shift(input alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational decoder that maps RV32I ALU-class instructions to {ip1, ip2, operation, rd, rd_we, illegal}.
// Defining ALU_ISSUE_M_EXT_EN enables the funct7=0000001 decode for MUL, DIV, DIVU, REM and REMU.
module alu_op_decode
  import alu_issue_pkg::*;
(
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic [XLEN-1:0] ip1,
  output logic [XLEN-1:0] ip2,
  output alu_op_t         operation,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic            illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  alu_op_t         op;
  logic            unused_rs1_idx;

  assign opcode         = instr[6:0];
  assign funct3         = instr[14:12];
  assign funct7         = instr[31:25];
  assign imm            = {{20{instr[31]}}, instr[31:20]};
  assign rd             = instr[11:7];
  assign unused_rs1_idx = ^instr[19:15];

  always_comb begin
    op    = OP_NONE;
    src_a = rs1_data;
    src_b = rs2_data;
    case (opcode)
      OPC_OP: begin
        case (funct7)
          F7_BASE: begin
            case (funct3)
              3'b000:  op = OP_ADD;
              3'b001:  op = OP_SLL;
              3'b011:  op = OP_SLTU;
              3'b100:  op = OP_XOR;
              3'b101:  op = OP_SRL;
              3'b110:  op = OP_OR;
              3'b111:  op = OP_AND;
              default: op = OP_NONE;
            endcase
          end
          F7_ALT: begin
            if (funct3 == 3'b000)      op = OP_SUB;
            else if (funct3 == 3'b101) op = OP_SRA;
          end
`ifdef ALU_ISSUE_M_EXT_EN
          F7_MULDIV: begin
            // MULH variants are deliberately left unmapped.
            case (funct3)
              3'b000:  op = OP_MUL;
              3'b100:  op = OP_DIV;
              3'b101:  op = OP_DIVU;
              3'b110:  op = OP_REM;
              3'b111:  op = OP_REMU;
              default: op = OP_NONE;
            endcase
          end
`endif
          default: op = OP_NONE;
        endcase
      end
      OPC_OP_IMM: begin
        src_b = imm;
        case (funct3)
          3'b000: op = OP_ADD;
          3'b001: op = (funct7 == F7_BASE) ? OP_SLL : OP_NONE;
          3'b011: op = OP_SLTU;
          3'b100: op = OP_XOR;
          3'b101: begin
            if (funct7 == F7_BASE)     op = OP_SRL;
            else if (funct7 == F7_ALT) op = OP_SRA;
          end
          3'b110:  op = OP_OR;
          3'b111:  op = OP_AND;
          default: op = OP_NONE;
        endcase
      end
      OPC_LUI: begin
        op    = OP_LUI;
        src_a = {12'b0, instr[31:12]};
        src_b = '0;
      end
      default: op = OP_NONE;
    endcase
  end

  // Shift amounts are masked here because the ALU shifts by the full ip2.
  always_comb begin
    operation = op;
    illegal   = (op == OP_NONE);
    rd_we     = !illegal && (rd != 5'd0);
    ip1       = illegal ? '0 : src_a;
    if (illegal)           ip2 = '0;
    else if (is_shift(op)) ip2 = {27'b0, src_b[4:0]};
    else                   ip2 = src_b;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage. It decodes each accepted instruction and holds the result in a 2-entry main/skid buffer.
// Valid/ready handshakes are used on both sides. The optional M decode is controlled by ALU_ISSUE_M_EXT_EN.
module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int OPW_P  = OPW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN_P-1:0] instr,
  input  logic [XLEN_P-1:0] rs1_data,
  input  logic [XLEN_P-1:0] rs2_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN_P-1:0] ip1,
  output logic [XLEN_P-1:0] ip2,
  output logic [OPW_P-1:0]  operation,
  output logic [4:0]        rd,
  output logic              rd_we,
  output logic              illegal
);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} state_t;

  state_t       state_reg;
  issue_entry_t main_reg;
  issue_entry_t skid_reg;
  issue_entry_t dec_entry;
  logic         in_ready_reg;
  logic         out_valid_reg;
  logic         accept;
  logic         issue;

  alu_op_decode u_decode (
    .instr     (instr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .ip1       (dec_entry.ip1),
    .ip2       (dec_entry.ip2),
    .operation (dec_entry.operation),
    .rd        (dec_entry.rd),
    .rd_we     (dec_entry.rd_we),
    .illegal   (dec_entry.illegal)
  );

  assign accept = in_valid && in_ready_reg;
  assign issue  = out_valid_reg && out_ready;

  // Flush has priority over a same-cycle accept or issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      main_reg      <= ENTRY_RESET;
      skid_reg      <= ENTRY_RESET;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else if (flush) begin
      state_reg     <= ST_EMPTY;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (accept) begin
            main_reg      <= dec_entry;
            out_valid_reg <= 1'b1;
            state_reg     <= ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && issue) begin
            main_reg <= dec_entry;
          end else if (accept) begin
            skid_reg     <= dec_entry;
            in_ready_reg <= 1'b0;
            state_reg    <= ST_TWO;
          end else if (issue) begin
            out_valid_reg <= 1'b0;
            state_reg     <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (issue) begin
            main_reg     <= skid_reg;
            in_ready_reg <= 1'b1;
            state_reg    <= ST_ONE;
          end
        end
        default: begin
          state_reg     <= ST_EMPTY;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign ip1       = main_reg.ip1;
  assign ip2       = main_reg.ip2;
  assign operation = main_reg.operation;
  assign rd        = main_reg.rd;
  assign rd_we     = main_reg.rd_we;
  assign illegal   = main_reg.illegal;

endmodule
